// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared constants for the write-back stage
// Purpose: datapath width, register count and MEM/WB ControlSig bit indices.
// Ports: none (package).
package wb_stage_pkg;

  localparam int WORD_SIZE = 16;
  localparam int NUM_REGS  = 4;

  // Bit positions inside MEM_WB_ControlSig
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_PCTOREG  = 2;

endpackage

// File: rtl/wb_stage_register_file.sv
// rtl/wb_stage_register_file.sv - 4-entry architectural register file with two read ports
// Purpose: one synchronous write port, two combinational read ports, optional
//   write-before-read bypass when WB_BYPASS_EN is defined.
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset (clears all entries)
//   Write_En, Write_Addr, Write_Data   write port, committed on the rising edge
//   Read_Addr1/2, Read_Data1/2         combinational read ports
// Macro: WB_BYPASS_EN - when defined, a read of the address being written this
//   cycle returns the incoming write data instead of the stored value.
module register_file
  import wb_stage_pkg::*;
#(
  parameter int WORD_SIZE = wb_stage_pkg::WORD_SIZE,
  parameter int NUM_REGS  = wb_stage_pkg::NUM_REGS
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Write_En,
  input  logic [1:0]           Write_Addr,
  input  logic [WORD_SIZE-1:0] Write_Data,
  input  logic [1:0]           Read_Addr1,
  input  logic [1:0]           Read_Addr2,
  output logic [WORD_SIZE-1:0] Read_Data1,
  output logic [WORD_SIZE-1:0] Read_Data2
);

  logic [WORD_SIZE-1:0] regs [NUM_REGS];

  // Register 0 is an ordinary register; there is no hard-wired zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (Write_En) begin
      regs[Write_Addr] <= Write_Data;
    end
  end

`ifdef WB_BYPASS_EN
  // Write-before-read: a same-cycle read of the destination sees the new value.
  assign Read_Data1 = (Write_En && (Read_Addr1 == Write_Addr)) ? Write_Data : regs[Read_Addr1];
  assign Read_Data2 = (Write_En && (Read_Addr2 == Write_Addr)) ? Write_Data : regs[Read_Addr2];
`else
  assign Read_Data1 = regs[Read_Addr1];
  assign Read_Data2 = regs[Read_Addr2];
`endif

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: MEM/WB consumer, register file, retire counter, WWD, halt
// Purpose: selects the write-back value, commits it to the register file,
//   counts retired instructions, latches WWD output and holds the halt flag.
// Ports:
//   Clk, Reset                       clock, asynchronous active-high reset
//   MEM_WB_*                         latched MEM/WB bundle (Valid=0 is a bubble)
//   ID_RegisterRs/Rt, ID_ReadData1/2 ID-stage read ports (combinational)
//   WB_WriteData, WB_RegWrite        selected value and effective enable, to forwarding
//   output_port                      last WWD operand
//   num_inst                         retired-instruction count (wraps)
//   is_halted                        sticky, set when HLT retires
// Macro: WB_BYPASS_EN - enables write-before-read bypass on the read ports.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int WORD_SIZE = wb_stage_pkg::WORD_SIZE,
  parameter int NUM_REGS  = wb_stage_pkg::NUM_REGS
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 MEM_WB_Valid,
  input  logic [2:0]           MEM_WB_ControlSig,
  input  logic                 MEM_WB_IsWWD,
  input  logic                 MEM_WB_IsHalt,
  input  logic [WORD_SIZE-1:0] MEM_WB_PCSource,
  input  logic [WORD_SIZE-1:0] MEM_WB_MemData,
  input  logic [WORD_SIZE-1:0] MEM_WB_ALUOut,
  input  logic [1:0]           MEM_WB_RegisterRd,
  input  logic [1:0]           ID_RegisterRs,
  input  logic [1:0]           ID_RegisterRt,
  output logic [WORD_SIZE-1:0] ID_ReadData1,
  output logic [WORD_SIZE-1:0] ID_ReadData2,
  output logic [WORD_SIZE-1:0] WB_WriteData,
  output logic                 WB_RegWrite,
  output logic [WORD_SIZE-1:0] output_port,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 is_halted
);

  logic retire;

  // Once halted nothing retires, so every piece of state freezes.
  assign retire      = MEM_WB_Valid && !is_halted;
  assign WB_RegWrite = retire && MEM_WB_ControlSig[CTRL_REGWRITE];

  // PCtoReg has priority over MemtoReg (JAL/JRL never load).
  always_comb begin
    WB_WriteData = MEM_WB_ALUOut;
    if (MEM_WB_ControlSig[CTRL_PCTOREG]) begin
      WB_WriteData = MEM_WB_PCSource;
    end else if (MEM_WB_ControlSig[CTRL_MEMTOREG]) begin
      WB_WriteData = MEM_WB_MemData;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      num_inst    <= '0;
      output_port <= '0;
      is_halted   <= 1'b0;
    end else if (retire) begin
      num_inst <= num_inst + WORD_SIZE'(1);
      if (MEM_WB_IsWWD) begin
        output_port <= MEM_WB_ALUOut;
      end
      if (MEM_WB_IsHalt) begin
        is_halted <= 1'b1;
      end
    end
  end

  register_file #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_REGS  (NUM_REGS)
  ) u_register_file (
    .Clk        (Clk),
    .Reset      (Reset),
    .Write_En   (WB_RegWrite),
    .Write_Addr (MEM_WB_RegisterRd),
    .Write_Data (WB_WriteData),
    .Read_Addr1 (ID_RegisterRs),
    .Read_Addr2 (ID_RegisterRt),
    .Read_Data1 (ID_ReadData1),
    .Read_Data2 (ID_ReadData2)
  );

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the 16-bit pipelined CPU: the consumer end of the MEM/WB pipeline register. Each cycle it takes the latched MEM/WB bundle, selects the write-back value, and commits it into the 4-entry architectural register file. It also serves the two ID-stage read ports, counts retired instructions, latches WWD output, and holds the halt flag.

## Interface
Parameters:
- WORD_SIZE, default 16: datapath width, taken from the shared constants.
- NUM_REGS, default 4: register count, addressed by 2 bits.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MEM_WB_Valid  in  1  bundle holds a real instruction; 0 marks a bubble.
- MEM_WB_ControlSig  in  3  bit0 RegWrite, bit1 MemtoReg, bit2 PCtoReg.
- MEM_WB_IsWWD  in  1  retiring instruction is WWD.
- MEM_WB_IsHalt  in  1  retiring instruction is HLT.
- MEM_WB_PCSource  in  WORD_SIZE  return address for JAL/JRL.
- MEM_WB_MemData  in  WORD_SIZE  load data.
- MEM_WB_ALUOut  in  WORD_SIZE  ALU result; also carries the WWD operand.
- MEM_WB_RegisterRd  in  2  destination register.
- ID_RegisterRs, ID_RegisterRt  in  2  read addresses.
- ID_ReadData1, ID_ReadData2  out  WORD_SIZE  read data (combinational).
- WB_WriteData  out  WORD_SIZE  selected write-back value, for the forwarding unit.
- WB_RegWrite  out  1  effective write enable, for the forwarding unit.
- output_port  out  WORD_SIZE  last WWD value.
- num_inst  out  WORD_SIZE  retired-instruction count.
- is_halted  out  1  HLT has retired.

## Operation
- Write-data mux: PCtoReg → PCSource; else MemtoReg → MemData; else ALUOut. If both PCtoReg and MemtoReg are set, PCtoReg wins.
- Retire = MEM_WB_Valid && !is_halted.
- WB_RegWrite = Retire && ControlSig[0]. When high, the posedge writes regs[RegisterRd] ← WB_WriteData.
- Every register is writable, including register 0; there is no hard-wired zero.
- num_inst increments by 1 on each posedge with Retire, including WWD and HLT. It wraps 0xFFFF → 0x0000.
- output_port ← MEM_WB_ALUOut on a posedge with Retire && IsWWD. Otherwise it holds.
- is_halted is set on a posedge with Retire && IsHalt. It stays sticky until Reset.
- Once is_halted is set, no further writes, counts or WWD updates occur.
- The HLT itself is counted.
- Bubbles (Valid=0) change no state, regardless of the other fields.

## Timing
- Reset (asynchronous, immediate): all registers 0x0000, num_inst 0, output_port 0, is_halted 0.
- Reset asserted mid-write: the write is lost and the register reads 0.
- Commit latency: one edge. A value presented in cycle N is architecturally visible after edge N.
- Read ports are combinational from regs, with bypass per Configuration.
- WB_WriteData and WB_RegWrite are combinational from the MEM/WB inputs and is_halted.
- There is no handshake and no stall: the block accepts one bundle per cycle unconditionally.

## Configuration
- WB_BYPASS_EN defined:
  - A read port whose address equals RegisterRd while WB_RegWrite is high returns WB_WriteData in the same cycle (write-before-read).
  - This removes the WB→ID hazard.
- WB_BYPASS_EN undefined:
  - Read ports return only the stored value, i.e. the old value in the write cycle.
  - The hazard unit must then stall one extra cycle.

## Structure
- Shared constants file holds:
  - WORD_SIZE
  - the ControlSig bit indices (CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_PCTOREG=2)
  - NUM_REGS
- One sub-module, register_file: 4×WORD_SIZE storage, one write port, two combinational read ports, and the optional bypass.
- wb_stage contains the mux, the counter, output_port and the halt logic.

## Test plan
- Reset, then read all four registers → 0x0000. num_inst=0, is_halted=0.
- ALU write: Valid=1, Ctrl=3'b001, Rd=2, ALUOut=0x1234 → after the edge, reg2=0x1234 and num_inst=1. Same-cycle read of Rs=2 returns 0x1234 with WB_BYPASS_EN defined, and the old value without it.
- Mux priority: Ctrl=3'b111, PCSource=0x0042, MemData=0xBEEF → reg written 0x0042. Ctrl=3'b011 → 0xBEEF.
- Bubble: Valid=0, Ctrl=3'b001, Rd=1, ALUOut=0xFFFF → reg1 and num_inst unchanged.
- WWD then HLT: WWD with ALUOut=0x00AA → output_port=0x00AA. HLT → is_halted=1 and num_inst incremented. A following valid write to reg3 is ignored. Asserting Reset clears everything.
- Counter wrap: preload 0xFFFF retires, then one more retire → num_inst=0x0000.
